adma_desc_ctrl: RTL
===================

# adma_desc_ctrl

Per-channel descriptor queue and transfer tracker, instantiated once per DMA write channel directly downstream of the CSR register map. It accepts descriptors pushed by RW1S writes, stores them in a DMA_DESC_DEPTH-entry ring, and issues them one at a time to the channel transfer engine. It counts words of the active transfer, retires completed descriptors, and produces the xfer_id, xfer_done, active_xfer_id, active_xfer_len and completion-IRQ status read back through the RO CSRs.

## Interface
- DMA_DESC_DEPTH, 4, ring entries; must be a power of 2, ≥2
- DMA_LENGTH_W, 16, xlen/ylen/stride/count width
- SRC_ADDR_W, 32, source address width
- DST_ADDR_W, 32, destination address width
- DMA_DESC_XFER_ID, $clog2(DMA_DESC_DEPTH), descriptor ID width; not user-set

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- dma_en, chn_ctrl_en, chn_xfer_2d, chn_xfer_cyclic, chn_irq_msk_irq_com  in  1 each  CSR controls
- irq_clr_i  in  1  single-cycle pulse; clears IRQ status
- desc_wr_vld_i / desc_wr_rdy_o  in/out  1  descriptor push handshake
- desc_src_addr_i, desc_dst_addr_i  in  SRC_ADDR_W/DST_ADDR_W  descriptor addresses
- desc_xfer_xlen_i, desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i  in  DMA_LENGTH_W  descriptor geometry
- eng_vld_o / eng_rdy_i  out/in  1  issue handshake to the transfer engine
- eng_id_o  out  DMA_DESC_XFER_ID  issued slot ID
- eng_src_addr_o, eng_dst_addr_o, eng_xlen_o, eng_ylen_o, eng_src_strd_o, eng_dst_strd_o  out  as inputs  issued descriptor
- eng_wd_done_i  in  1  one destination word written
- chn_irq_src_irq_com  out  1  sticky completion IRQ status
- xfer_id  out  DMA_DESC_XFER_ID  ID the next pushed descriptor receives
- xfer_done  out  DMA_DESC_DEPTH  per-slot done bitmap
- active_xfer_id  out  DMA_DESC_XFER_ID  slot of the issued or active descriptor
- active_xfer_len  out  DMA_LENGTH_W  words remaining in the current row

## Operation
- Ring storage:
  - wr_ptr, rd_ptr and count are registered; pointers wrap modulo DMA_DESC_DEPTH.
  - desc_wr_rdy_o = (count != DMA_DESC_DEPTH), from registered state only. A slot freed by a retire becomes writable the next cycle; no same-cycle bypass.
  - Push: stores the descriptor at wr_ptr, clears xfer_done[wr_ptr], increments wr_ptr.
  - xfer_id = wr_ptr.
- FSM states:
  - IDLE → ISSUE when dma_en & chn_ctrl_en & count≠0. Head is latched into the eng_* registers. eng_vld_o and active_xfer_id = rd_ptr are asserted.
  - ISSUE holds eng_vld_o and all eng_* outputs stable until eng_rdy_i, even if the enables drop. On handshake → ACTIVE.
    - row_cnt is loaded with ylen when chn_xfer_2d=1, else 1.
    - active_xfer_len is loaded with xlen.
  - ACTIVE: each eng_wd_done_i decrements active_xfer_len.
    - When active_xfer_len reaches 0 and rows remain, row_cnt decrements and active_xfer_len reloads xlen.
    - The word that drains the last row retires the descriptor → IDLE.
  - eng_wd_done_i outside ACTIVE is ignored.
- Zero length: xlen=0, or ylen=0 with 2D. The descriptor is never issued. It retires directly from IDLE in one cycle; eng_vld_o stays 0.
- Retire, registered on the next edge:
  - xfer_done[rd_ptr] is set.
  - If chn_irq_msk_irq_com=1, chn_irq_src_irq_com is set.
  - If chn_xfer_cyclic=0 at retire: rd_ptr increments and count decrements.
  - If chn_xfer_cyclic=1: the head stays and is reissued.
- IRQ: irq_clr_i clears chn_irq_src_irq_com. A retire and a clear in the same cycle leave it set.
- Simultaneous push and non-cyclic retire: count is unchanged and both pointers advance.
- Disabling chn_ctrl_en or dma_en only blocks IDLE→ISSUE. An issued or active transfer runs to retire; pushes are still accepted.
- Reset mid-transfer: queue contents are discarded, all state returns to reset values, and no retire is generated.

## Timing
- Reset values:
  - desc_wr_rdy_o=1, eng_vld_o=0, eng_* data=0.
  - xfer_id=0, xfer_done=0, active_xfer_id=0, active_xfer_len=0, chn_irq_src_irq_com=0.
  - FSM=IDLE.
- Push accepted at edge N with the channel enabled and idle: eng_vld_o is high from N+1.
- Last eng_wd_done_i at edge M: xfer_done, IRQ and pointers update at M+1, FSM returns to IDLE at M+1, and the earliest reissue is eng_vld_o at M+2.
- active_xfer_len updates on the edge after each eng_wd_done_i.

## Structure
- Shared package adma_pkg holds:
  - a desc_t packed struct with src, dst, xlen, ylen, src_strd and dst_strd;
  - the FSM enum (IDLE/ISSUE/ACTIVE).
- Sub-module adma_desc_ring holds the storage array, pointers and count, with push/peek/pop. The FSM, counters and status live in adma_desc_ctrl.

## Test plan
- Enabled channel, push 1D xlen=3, eng_rdy_i=1, 3 wd_done pulses:
  - eng_vld_o is high the cycle after the push;
  - active_xfer_len reads 3→2→1→0;
  - xfer_done=0001 one cycle after the 3rd pulse;
  - IRQ set if the mask bit is 1.
- Channel disabled, push 4 descriptors:
  - desc_wr_rdy_o=0 after the 4th and xfer_id=0;
  - a 5th push is held;
  - enable and retire one: rdy returns the cycle after the retire and the held push takes ID 0, clearing xfer_done[0].
- 2D with xlen=2, ylen=3: 6 wd_done pulses are needed, active_xfer_len reloads 2 after each row, and the retire comes after the 6th.
- Cyclic=1, one descriptor of xlen=1: it is reissued with the same eng_id_o after each retire and count stays 1; clearing cyclic lets the next retire pop it.
- Edge cases:
  - xlen=0 retires without eng_vld_o;
  - retire and irq_clr_i in the same cycle leave the IRQ set;
  - deassert aresetn while ACTIVE: all outputs at reset values and xfer_done=0.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared types for the per-channel DMA descriptor controller.
// desc_t   : one descriptor as pushed through the CSR map (addresses, geometry, strides)
// state_t  : issue/transfer FSM states
// The ADMA_* widths fix the desc_t layout; the matching module parameters of
// adma_desc_ctrl must be left at these values.
package adma_pkg;

  localparam int unsigned ADMA_LENGTH_W   = 16;
  localparam int unsigned ADMA_SRC_ADDR_W = 32;
  localparam int unsigned ADMA_DST_ADDR_W = 32;

  typedef struct packed {
    logic [ADMA_SRC_ADDR_W-1:0] src;
    logic [ADMA_DST_ADDR_W-1:0] dst;
    logic [ADMA_LENGTH_W-1:0]   xlen;
    logic [ADMA_LENGTH_W-1:0]   ylen;
    logic [ADMA_LENGTH_W-1:0]   src_strd;
    logic [ADMA_LENGTH_W-1:0]   dst_strd;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/adma_desc_ring.sv
// Descriptor ring: DEPTH-entry storage with write/read pointers and occupancy.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_desc    store push_desc at wr_ptr
//   pop                retire the head entry
//   head               entry at rd_ptr (peek)
//   wr_ptr, rd_ptr     ring pointers, wrap modulo DEPTH
//   count              number of occupied entries
//   full               count == DEPTH
module adma_desc_ring
  import adma_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  desc_t            push_desc,
  input  logic             pop,
  output desc_t            head,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full
);

  desc_t mem [DEPTH];

  // Storage is not reset: contents are only ever read through rd_ptr/count,
  // which are reset, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_desc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/adma_desc_ctrl.sv
// Per-channel descriptor queue and transfer tracker.
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   dma_en, chn_ctrl_en                 both must be set to start a new descriptor
//   chn_xfer_2d, chn_xfer_cyclic        geometry mode, reissue-head mode
//   chn_irq_msk_irq_com, irq_clr_i      completion IRQ enable, status clear pulse
//   desc_wr_vld_i/desc_wr_rdy_o, desc_* descriptor push
//   eng_vld_o/eng_rdy_i, eng_*          descriptor issue to the transfer engine
//   eng_wd_done_i                       one destination word written
//   chn_irq_src_irq_com                 sticky completion IRQ status
//   xfer_id, xfer_done                  next push slot, per-slot done bitmap
//   active_xfer_id, active_xfer_len     issued slot, words left in current row
module adma_desc_ctrl
  import adma_pkg::*;
#(
  parameter  int unsigned DMA_DESC_DEPTH   = 4,
  parameter  int unsigned DMA_LENGTH_W     = ADMA_LENGTH_W,
  parameter  int unsigned SRC_ADDR_W       = ADMA_SRC_ADDR_W,
  parameter  int unsigned DST_ADDR_W       = ADMA_DST_ADDR_W,
  localparam int unsigned DMA_DESC_XFER_ID = $clog2(DMA_DESC_DEPTH)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        dma_en,
  input  logic                        chn_ctrl_en,
  input  logic                        chn_xfer_2d,
  input  logic                        chn_xfer_cyclic,
  input  logic                        chn_irq_msk_irq_com,
  input  logic                        irq_clr_i,
  input  logic                        desc_wr_vld_i,
  output logic                        desc_wr_rdy_o,
  input  logic [SRC_ADDR_W-1:0]       desc_src_addr_i,
  input  logic [DST_ADDR_W-1:0]       desc_dst_addr_i,
  input  logic [DMA_LENGTH_W-1:0]     desc_xfer_xlen_i,
  input  logic [DMA_LENGTH_W-1:0]     desc_xfer_ylen_i,
  input  logic [DMA_LENGTH_W-1:0]     desc_src_strd_i,
  input  logic [DMA_LENGTH_W-1:0]     desc_dst_strd_i,
  output logic                        eng_vld_o,
  input  logic                        eng_rdy_i,
  output logic [DMA_DESC_XFER_ID-1:0] eng_id_o,
  output logic [SRC_ADDR_W-1:0]       eng_src_addr_o,
  output logic [DST_ADDR_W-1:0]       eng_dst_addr_o,
  output logic [DMA_LENGTH_W-1:0]     eng_xlen_o,
  output logic [DMA_LENGTH_W-1:0]     eng_ylen_o,
  output logic [DMA_LENGTH_W-1:0]     eng_src_strd_o,
  output logic [DMA_LENGTH_W-1:0]     eng_dst_strd_o,
  input  logic                        eng_wd_done_i,
  output logic                        chn_irq_src_irq_com,
  output logic [DMA_DESC_XFER_ID-1:0] xfer_id,
  output logic [DMA_DESC_DEPTH-1:0]   xfer_done,
  output logic [DMA_DESC_XFER_ID-1:0] active_xfer_id,
  output logic [DMA_LENGTH_W-1:0]     active_xfer_len
);

  state_t                      state, state_nxt;
  desc_t                       push_desc, head;
  logic [DMA_DESC_XFER_ID-1:0] wr_ptr, rd_ptr;
  logic [DMA_DESC_XFER_ID:0]   count;
  logic                        full, push, pop;
  logic                        retire, latch, start;
  logic                        zero_len, last_word;
  logic [DMA_LENGTH_W-1:0]     row_cnt;

  assign push_desc = '{src:      desc_src_addr_i,
                       dst:      desc_dst_addr_i,
                       xlen:     desc_xfer_xlen_i,
                       ylen:     desc_xfer_ylen_i,
                       src_strd: desc_src_strd_i,
                       dst_strd: desc_dst_strd_i};

  adma_desc_ring #(
    .DEPTH (DMA_DESC_DEPTH)
  ) u_ring (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (push),
    .push_desc (push_desc),
    .pop       (pop),
    .head      (head),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full)
  );

  assign desc_wr_rdy_o = !full;
  assign push          = desc_wr_vld_i && desc_wr_rdy_o;
  assign pop           = retire && !chn_xfer_cyclic;
  assign xfer_id       = wr_ptr;
  assign eng_vld_o     = (state == ISSUE);
  assign eng_id_o      = active_xfer_id;

  assign zero_len  = (head.xlen == '0) || (chn_xfer_2d && (head.ylen == '0));
  // Word that empties the final row; row_cnt<=1 also covers a 2D ylen of 0
  // reaching the engine if chn_xfer_2d toggled between latch and handshake.
  assign last_word = eng_wd_done_i && (active_xfer_len == DMA_LENGTH_W'(1)) &&
                     (row_cnt <= DMA_LENGTH_W'(1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    latch     = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (dma_en && chn_ctrl_en && (count != '0)) begin
          if (zero_len) begin
            retire = 1'b1;
          end else begin
            latch     = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (eng_rdy_i) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (last_word) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      eng_src_addr_o  <= '0;
      eng_dst_addr_o  <= '0;
      eng_xlen_o      <= '0;
      eng_ylen_o      <= '0;
      eng_src_strd_o  <= '0;
      eng_dst_strd_o  <= '0;
      active_xfer_id  <= '0;
      active_xfer_len <= '0;
      row_cnt         <= '0;
    end else begin
      if (latch) begin
        eng_src_addr_o <= head.src;
        eng_dst_addr_o <= head.dst;
        eng_xlen_o     <= head.xlen;
        eng_ylen_o     <= head.ylen;
        eng_src_strd_o <= head.src_strd;
        eng_dst_strd_o <= head.dst_strd;
        active_xfer_id <= rd_ptr;
      end
      if (start) begin
        row_cnt         <= chn_xfer_2d ? eng_ylen_o : DMA_LENGTH_W'(1);
        active_xfer_len <= eng_xlen_o;
      end else if ((state == ACTIVE) && eng_wd_done_i) begin
        // Row drained with rows left: reload immediately rather than show 0.
        if ((active_xfer_len == DMA_LENGTH_W'(1)) && (row_cnt > DMA_LENGTH_W'(1))) begin
          row_cnt         <= row_cnt - 1'b1;
          active_xfer_len <= eng_xlen_o;
        end else begin
          active_xfer_len <= active_xfer_len - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      xfer_done           <= '0;
      chn_irq_src_irq_com <= 1'b0;
    end else begin
      // A push never targets rd_ptr while a retire is pending (ring would be full).
      if (push)   xfer_done[wr_ptr] <= 1'b0;
      if (retire) xfer_done[rd_ptr] <= 1'b1;
      if (retire && chn_irq_msk_irq_com) chn_irq_src_irq_com <= 1'b1;
      else if (irq_clr_i)                chn_irq_src_irq_com <= 1'b0;
    end
  end

endmodule
